// File: rtl/tag_index_arbiter.sv
// Round-robin AR/AW front-end: issues a set-index tag read, then pushes {dir, tid, addr} to the tag FIFO.
// Optional macro TAG_INDEX_HASH_EN folds the next INDEX_WIDTH address bits into the set index by XOR.
module tag_index_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned INDEX_WIDTH     = 4,
  parameter int unsigned OFFSET_WIDTH    = 4,
  parameter int unsigned TID_WIDTH       = 10,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [ID_WIDTH-1:0]                      arid_i,
  input  logic [ADDR_WIDTH-1:0]                    araddr_i,
  input  logic [7:0]                               arlen_i,
  input  logic                                     arvalid_i,
  output logic                                     arready_o,
  input  logic [ID_WIDTH-1:0]                      awid_i,
  input  logic [ADDR_WIDTH-1:0]                    awaddr_i,
  input  logic [7:0]                               awlen_i,
  input  logic                                     awvalid_i,
  output logic                                     awready_o,
  output logic [ID_WIDTH-1:0]                      arid_o,
  output logic [ADDR_WIDTH-1:0]                    araddr_o,
  output logic [7:0]                               arlen_o,
  output logic                                     arvalid_o,
  input  logic                                     arready_i,
  input  logic                                     tag_fifo_afull_i,
  output logic                                     tag_fifo_wren_o,
  output logic [TID_WIDTH+ADDR_WIDTH:0]            tag_fifo_data_o,
  input  logic                                     done_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     inflight_o
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DATA_W = 1 + TID_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_PUSH} state_e;

  state_e state_q, state_d;

  logic                  arvalid_q, arvalid_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  dir_q, dir_d;
  logic                  last_wr_q, last_wr_d;
  logic                  wren_q, wren_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [TID_WIDTH-1:0]  tid_q, tid_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;

  logic                   eligible_c;
  logic                   grant_wr_c;
  logic                   accept_c;
  logic [ID_WIDTH-1:0]    sel_id_c;
  logic [7:0]             sel_len_c;
  logic [ADDR_WIDTH-1:0]  sel_addr_c;
  logic [INDEX_WIDTH-1:0] index_c;
  logic [ADDR_WIDTH-1:0]  index_addr_c;
  logic [TID_WIDTH-1:0]   tid_next_c;

  // Arbitration: only in IDLE, with FIFO room and below the in-flight cap; ties go opposite the last grant.
  assign eligible_c = (state_q == S_IDLE) && !tag_fifo_afull_i &&
                      (inflight_q < CNT_W'(MAX_OUTSTANDING));
  assign grant_wr_c = awvalid_i && (!arvalid_i || !last_wr_q);
  assign arready_o  = eligible_c && arvalid_i && !grant_wr_c;
  assign awready_o  = eligible_c && grant_wr_c;
  assign accept_c   = arready_o || awready_o;

  assign sel_id_c   = grant_wr_c ? awid_i   : arid_i;
  assign sel_len_c  = grant_wr_c ? awlen_i  : arlen_i;
  assign sel_addr_c = grant_wr_c ? awaddr_i : araddr_i;

`ifdef TAG_INDEX_HASH_EN
  assign index_c = sel_addr_c[OFFSET_WIDTH +: INDEX_WIDTH] ^
                   sel_addr_c[OFFSET_WIDTH + INDEX_WIDTH +: INDEX_WIDTH];
`else
  assign index_c = sel_addr_c[OFFSET_WIDTH +: INDEX_WIDTH];
`endif

  assign index_addr_c = ADDR_WIDTH'(index_c) << OFFSET_WIDTH;

  // TID 0 is reserved, so the counter wraps from all-ones back to 1.
  assign tid_next_c = (tid_q == {TID_WIDTH{1'b1}}) ? TID_WIDTH'(1) : tid_q + TID_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c)  state_d = S_ISSUE;
      S_ISSUE: if (arready_i) state_d = S_PUSH;
      S_PUSH:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid_d  = arvalid_q;
    arid_d     = arid_q;
    arlen_d    = arlen_q;
    araddr_d   = araddr_q;
    addr_d     = addr_q;
    dir_d      = dir_q;
    last_wr_d  = last_wr_q;
    wren_d     = 1'b0;
    data_d     = data_q;
    tid_d      = tid_q;
    inflight_d = inflight_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          arvalid_d = 1'b1;
          arid_d    = sel_id_c;
          arlen_d   = sel_len_c;
          araddr_d  = index_addr_c;
          addr_d    = sel_addr_c;
          dir_d     = grant_wr_c;
          last_wr_d = grant_wr_c;
        end
      end
      S_ISSUE: begin
        if (arready_i) begin
          arvalid_d = 1'b0;
          wren_d    = 1'b1;
          data_d    = {dir_q, tid_q, addr_q};
        end
      end
      S_PUSH:  tid_d = tid_next_c;
      default: ;
    endcase
    // A retire arriving in the push cycle cancels the increment; retires at zero are dropped.
    if (wren_q && !done_i) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!wren_q && done_i && (inflight_q != '0)) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid_q  <= 1'b0;
      arid_q     <= '0;
      arlen_q    <= '0;
      araddr_q   <= '0;
      addr_q     <= '0;
      dir_q      <= 1'b0;
      last_wr_q  <= 1'b1;
      wren_q     <= 1'b0;
      data_q     <= '0;
      tid_q      <= TID_WIDTH'(1);
      inflight_q <= '0;
    end else begin
      arvalid_q  <= arvalid_d;
      arid_q     <= arid_d;
      arlen_q    <= arlen_d;
      araddr_q   <= araddr_d;
      addr_q     <= addr_d;
      dir_q      <= dir_d;
      last_wr_q  <= last_wr_d;
      wren_q     <= wren_d;
      data_q     <= data_d;
      tid_q      <= tid_d;
      inflight_q <= inflight_d;
    end
  end

  assign arvalid_o       = arvalid_q;
  assign arid_o          = arid_q;
  assign arlen_o         = arlen_q;
  assign araddr_o        = araddr_q;
  assign tag_fifo_wren_o = wren_q;
  assign tag_fifo_data_o = data_q;
  assign inflight_o      = inflight_q;

endmodule

// File: tb/tb_tag_index_arbiter.sv
// Bench for tag_index_arbiter (TID_WIDTH=2, MAX_OUTSTANDING=2): transaction model checked every cycle
// plus directed scenarios with literal expectations.
module tb_tag_index_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned IW = 16;
  localparam int unsigned TW = 2;
  localparam int unsigned MO = 2;
  localparam int unsigned CW = $clog2(MO + 1);
  localparam int unsigned DW = 1 + TW + AW;
  localparam int TID_MAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [IW-1:0] arid = '0, awid = '0;
  logic [AW-1:0] araddr = '0, awaddr = '0;
  logic [7:0]    arlen = '0, awlen = '0;
  logic          arvalid = 1'b0, awvalid = 1'b0;
  logic          arready_in = 1'b0, afull = 1'b0, done = 1'b0;
  logic          arready_o, awready_o, arvalid_o, wren_o;
  logic [IW-1:0] arid_o;
  logic [AW-1:0] araddr_o;
  logic [7:0]    arlen_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] inflight_o;

  int n_cmp = 0;
  int n_err = 0;

  tag_index_arbiter #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .INDEX_WIDTH(4), .OFFSET_WIDTH(4),
    .TID_WIDTH(TW), .MAX_OUTSTANDING(MO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arvalid_i(arvalid), .arready_o(arready_o),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awvalid_i(awvalid), .awready_o(awready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arvalid_o(arvalid_o),
    .arready_i(arready_in), .tag_fifo_afull_i(afull),
    .tag_fifo_wren_o(wren_o), .tag_fifo_data_o(data_o),
    .done_i(done), .inflight_o(inflight_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Set-index address derived arithmetically from the line address.
  function automatic logic [AW-1:0] index_addr(input logic [AW-1:0] a);
    longint unsigned lo, hi, f;
    lo = (a >> 4) % 16;
    hi = (a >> 8) % 16;
`ifdef TAG_INDEX_HASH_EN
    f = lo ^ hi;
`else
    f = lo;
`endif
    return AW'(f * 16);
  endfunction

  // Transaction model: one request may be in the pipe; it issues, then pushes, then frees the arbiter.
  bit            m_busy, m_arv, m_push, m_dir, m_last;
  logic [IW-1:0] m_id;
  logic [7:0]    m_len;
  logic [AW-1:0] m_iaddr, m_addr;
  int            m_tid, m_infl;
  logic [DW-1:0] push_log[$];

  always @(negedge clk) begin
    bit elig, gw, e_ar, e_aw, was_push;
    logic [DW-1:0] exp_data;
    if (!rst_n) begin
      m_busy = 0; m_arv = 0; m_push = 0; m_dir = 0; m_last = 1;
      m_tid = 1; m_infl = 0;
      chk("rst_arvalid", 128'(arvalid_o), 128'(0));
      chk("rst_wren", 128'(wren_o), 128'(0));
      chk("rst_inflight", 128'(inflight_o), 128'(0));
    end else begin
      elig = !afull && (m_infl < MO);
      gw   = awvalid && (!arvalid || !m_last);
      e_ar = !m_busy && elig && arvalid && !gw;
      e_aw = !m_busy && elig && gw;
      chk("arready", 128'(arready_o), 128'(e_ar));
      chk("awready", 128'(awready_o), 128'(e_aw));
      chk("arvalid", 128'(arvalid_o), 128'(m_arv));
      chk("wren", 128'(wren_o), 128'(m_push));
      chk("inflight", 128'(inflight_o), 128'(m_infl));
      if (m_arv) begin
        chk("arid", 128'(arid_o), 128'(m_id));
        chk("arlen", 128'(arlen_o), 128'(m_len));
        chk("araddr", 128'(araddr_o), 128'(m_iaddr));
      end
      if (m_push) begin
        exp_data = {m_dir, m_tid[TW-1:0], m_addr};
        chk("fifo_data", 128'(data_o), 128'(exp_data));
      end
      if (wren_o) push_log.push_back(data_o);
      was_push = m_push;
      if (m_push) begin
        m_tid  = (m_tid == TID_MAX) ? 1 : m_tid + 1;
        m_push = 0;
        m_busy = 0;
      end else if (m_arv && arready_in) begin
        m_arv  = 0;
        m_push = 1;
      end else if (e_ar || e_aw) begin
        m_busy  = 1;
        m_arv   = 1;
        m_dir   = e_aw;
        m_last  = e_aw;
        m_id    = e_aw ? awid : arid;
        m_len   = e_aw ? awlen : arlen;
        m_addr  = e_aw ? awaddr : araddr;
        m_iaddr = index_addr(m_addr);
      end
      if (was_push && !done) m_infl++;
      else if (!was_push && done && m_infl > 0) m_infl--;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pushes(input int target, input int budget);
    int k = 0;
    while (push_log.size() < target && k < budget) begin
      cyc(1);
      k++;
    end
    chk("push_timeout", 128'(push_log.size() >= target), 128'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    logic [DW-1:0] exp1;
    int exp_dir[4] = '{0, 1, 0, 1};
    int exp_tid[4] = '{1, 2, 3, 1};
    logic [DW-1:0] rec;

    #1 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk("reset_inflight", 128'(inflight_o), 128'(0));
    chk("reset_arvalid", 128'(arvalid_o), 128'(0));

    // Single read with arready tied high.
    arready_in = 1'b1;
    arvalid = 1'b1; araddr = 64'h0000_0000_1234_5670; arid = 16'h0005; arlen = 8'd3;
    #1 chk("single_arready", 128'(arready_o), 128'(1));
    cyc(1);
    arvalid = 1'b0;
    chk("single_arvalid_T1", 128'(arvalid_o), 128'(1));
`ifdef TAG_INDEX_HASH_EN
    chk("single_araddr", 128'(araddr_o), 128'(64'h10));
`else
    chk("single_araddr", 128'(araddr_o), 128'(64'h70));
`endif
    chk("single_arid", 128'(arid_o), 128'(16'h0005));
    cyc(1);
    exp1 = {1'b0, 2'd1, 64'h0000_0000_1234_5670};
    chk("single_wren_T2", 128'(wren_o), 128'(1));
    chk("single_data", 128'(data_o), 128'(exp1));
    cyc(1);
    chk("single_wren_T3", 128'(wren_o), 128'(0));
    chk("single_inflight", 128'(inflight_o), 128'(1));
    done = 1'b1; cyc(1); done = 1'b0;

    // Both channels valid: alternate grants, tids wrap 1,2,3,1.
    do_reset();
    base = push_log.size();
    done = 1'b1;
    arvalid = 1'b1; araddr = 64'h0000_0000_0000_0AB0; arid = 16'h0011; arlen = 8'd1;
    awvalid = 1'b1; awaddr = 64'h0000_0000_0000_3CD0; awid = 16'h0022; awlen = 8'd7;
    wait_pushes(base + 4, 40);
    arvalid = 1'b0; awvalid = 1'b0;
    cyc(1);
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rec = (push_log.size() > base + i) ? push_log[base + i] : '0;
      chk($sformatf("rr_dir%0d", i), 128'(rec[DW-1]), 128'(exp_dir[i]));
      chk($sformatf("rr_tid%0d", i), 128'(rec[DW-2 -: TW]), 128'(exp_tid[i]));
    end

    // In-flight cap of 2, release by done, push+done in one cycle.
    base = push_log.size();
    arvalid = 1'b1; araddr = 64'h0000_0000_0000_5550; arid = 16'h0033;
    wait_pushes(base + 2, 20);
    cyc(3);
    chk("cap_arready", 128'(arready_o), 128'(0));
    chk("cap_inflight", 128'(inflight_o), 128'(2));
    done = 1'b1; cyc(1); done = 1'b0;
    chk("cap_release_arready", 128'(arready_o), 128'(1));
    cyc(1);
    arvalid = 1'b0;
    cyc(1);
    chk("cap_push_wren", 128'(wren_o), 128'(1));
    done = 1'b1; cyc(1); done = 1'b0;
    chk("push_done_inflight", 128'(inflight_o), 128'(1));
    done = 1'b1; cyc(1); done = 1'b0;

    // Almost-full blocks in IDLE but not a captured request.
    base = push_log.size();
    afull = 1'b1;
    arvalid = 1'b1; araddr = 64'h0000_0000_0000_0F40; arid = 16'h0044;
    cyc(3);
    chk("afull_arready", 128'(arready_o), 128'(0));
    afull = 1'b0;
    #1 chk("afull_clear_arready", 128'(arready_o), 128'(1));
    cyc(1);
    arvalid = 1'b0; afull = 1'b1; arready_in = 1'b0;
    cyc(2);
    arready_in = 1'b1;
    wait_pushes(base + 1, 10);
    afull = 1'b0;
    cyc(1);

    // Reset while stalled in ISSUE: drop request, restart tid at 1.
    arready_in = 1'b0;
    arvalid = 1'b1; araddr = 64'h0000_0000_0000_0770; arid = 16'h0055;
    cyc(1);
    arvalid = 1'b0;
    cyc(5);
    chk("stall_arvalid", 128'(arvalid_o), 128'(1));
    base = push_log.size();
    #1 rst_n = 1'b0;
    #1;
    chk("async_arvalid", 128'(arvalid_o), 128'(0));
    chk("async_wren", 128'(wren_o), 128'(0));
    chk("async_inflight", 128'(inflight_o), 128'(0));
    cyc(2);
    rst_n = 1'b1;
    arready_in = 1'b1;
    cyc(1);
    chk("no_push_after_reset", 128'(push_log.size()), 128'(base));
    arvalid = 1'b1; araddr = 64'h0000_0000_0000_0990; arid = 16'h0066;
    cyc(1);
    arvalid = 1'b0;
    wait_pushes(base + 1, 10);
    rec = (push_log.size() > base) ? push_log[base] : '0;
    chk("tid_after_reset", 128'(rec[DW-2 -: TW]), 128'(1));
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
